// File: rtl/sm_pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sm_pipe_pkg : state encodings for the sm_pipe_skid stage          |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package sm_pipe_pkg;

  localparam logic [1:0] C_ST_EMPTY = 2'd0;
  localparam logic [1:0] C_ST_BUSY  = 2'd1;
  localparam logic [1:0] C_ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = C_ST_EMPTY,
    BUSY  = C_ST_BUSY,
    FULL  = C_ST_FULL
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sm_pipe_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sm_pipe_slot : load-enable data register, async reset to zero     |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module sm_pipe_slot
  import sm_pipe_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/sm_pipe_skid.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sm_pipe_skid : two-entry ready/valid skid buffer with registered  |
// |                in_ready; optional flush via SM_PIPE_FLUSH_EN      |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module sm_pipe_skid
  import sm_pipe_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data
`ifdef SM_PIPE_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_main_ld;
  logic            w_skid_ld;
  logic            w_main_from_skid;
  logic [SIZE-1:0] w_main_d;
  logic [SIZE-1:0] w_skid_q;

  // Handshake outputs decode straight from the state flops.
  assign out_valid  = (r_state != EMPTY);
  assign in_ready   = (r_state != FULL);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = BUSY;
          w_main_ld   = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_nxt = FULL;
          w_skid_ld   = 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_state_nxt = EMPTY;
        end else if (w_in_xfer && w_out_xfer) begin
          w_main_ld   = 1'b1;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_state_nxt      = BUSY;
          w_main_ld        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
`ifdef SM_PIPE_FLUSH_EN
    // Squash wins over any transfer; held data stays but is marked invalid.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_ld   = 1'b0;
      w_skid_ld   = 1'b0;
    end
`endif
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  sm_pipe_slot #(.SIZE(SIZE)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (w_main_ld),
    .d    (w_main_d),
    .q    (out_data)
  );

  sm_pipe_slot #(.SIZE(SIZE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (w_skid_ld),
    .d    (in_data),
    .q    (w_skid_q)
  );

endmodule
`default_nettype wire

// File: doc/sm_pipe_skid.md
Name: sm_pipe_skid

Overview:
- Two-entry ready/valid pipeline stage (skid buffer) placed between adjacent CPU pipeline stages, e.g. fetch→decode.
- Breaks the combinational ready path, so upstream in_ready is a registered signal.
- Sustains one transfer per clock with no bubbles; absorbs one extra word when downstream stalls.
- Optional synchronous flush for branch/exception squash.

Parameters:
- SIZE, 32, width of the data word carried through the stage.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  upstream word present on in_data
- in_ready  output  1  stage can accept a word this cycle (registered)
- in_data  input  SIZE  upstream data
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  SIZE  data to downstream (registered)
- flush  input  1  discard all held words (present only with SM_PIPE_FLUSH_EN)

Behaviour:
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready, both at the rising clk edge.
- Storage: main register (drives out_data) and skid register.
- States (sm_pipe_pkg::state_t):
  - EMPTY: out_valid=0, in_ready=1
  - BUSY: main holds a word; out_valid=1, in_ready=1
  - FULL: main and skid both hold words; out_valid=1, in_ready=0
- Transitions:
  - EMPTY + in-transfer → BUSY; main<=in_data.
  - BUSY + in-transfer, no out-transfer → FULL; skid<=in_data.
  - BUSY + out-transfer, no in-transfer → EMPTY.
  - BUSY + both → BUSY; main<=in_data.
  - FULL + out-transfer → BUSY; main<=skid. No in-transfer is possible because in_ready=0.
  - All other cases: hold state and data.
- Outputs are registered or decoded directly from state flops; no combinational path from in_valid or out_ready to any output.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- Ordering: strict FIFO, no loss, no duplication.
- Data registers change only on the events listed above; out_data holds its value while out_valid=1 and out_ready=0.
- out_data is don't-care when out_valid=0 but must not be X after reset.
- in_valid while in_ready=0 is legal; the word is not taken. Upstream must hold it stable.
- Reset (asynchronous, active-high): state<=EMPTY, main<=0, skid<=0. Outputs during and after reset: in_ready=1, out_valid=0, out_data=0. Reset mid-operation discards held words.

Optional Feature:
- Macro: SM_PIPE_FLUSH_EN
- Defined:
  - flush port exists.
  - flush=1 at an edge forces state<=EMPTY. Data registers are not cleared.
  - flush has priority over a simultaneous in-transfer or out-transfer; both words are dropped.
  - Next cycle: in_ready=1, out_valid=0.
- Undefined: no flush port; behaviour is exactly as specified above.

Decomposition:
- Package sm_pipe_pkg:
  - state_t enum (EMPTY, BUSY, FULL), 2 bits.
  - Localparam encodings for the three states.
- Sub-module sm_pipe_slot:
  - SIZE-wide load-enable data register with asynchronous active-high reset to 0.
  - Instantiated twice (main, skid).
- Top level contains the state machine and the mux selecting in_data or skid into main.

Test Plan:
- Reset:
  - Assert rst mid-cycle with state FULL.
  - Expect immediately out_valid=0, in_ready=1, out_data=0.
  - After release, first word 0x0000_00A5 appears one edge after acceptance.
- Streaming:
  - in_valid=1 with words 1,2,3,4 on consecutive cycles, out_ready=1 throughout.
  - Expect outputs 1,2,3,4 on consecutive cycles, in_ready always 1, no bubbles.
- Stall/skid:
  - Send 0x11, 0x22, 0x33 back-to-back with out_ready=0 from the second cycle.
  - Expect state FULL after 0x22, in_ready=0, 0x33 held upstream.
  - Raise out_ready; expect 0x11, 0x22, 0x33 in order with no loss.
- Simultaneous in/out in BUSY:
  - Main holds 0x5, in_data=0x6, in_valid=1, out_ready=1.
  - Expect out_data=0x6, state BUSY.
- Random backpressure:
  - 1000 words, random in_valid/out_ready.
  - Scoreboard confirms order and count.
  - in_ready and out_valid never change combinationally with inputs.
- Flush (SM_PIPE_FLUSH_EN):
  - In FULL (0x7, 0x8), assert flush together with out_ready=1 and in_valid=1, in_data=0x9.
  - Expect next cycle out_valid=0, in_ready=1; 0x7, 0x8 and 0x9 never appear at the output.
